// File: rtl/qam_mod_scheduler_pkg.sv
// Shared types and default timing constants for the QAM-16 modulator burst scheduler.
package parameter_def;

  typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} qam_sched_state_t;

  localparam int SAMPLE_DIV_DEF   = 6;
  localparam int DRAIN_CYCLES_DEF = 4;

endpackage

// File: rtl/qam_strobe_gen.sv
// Modulo-SAMPLE_DIV sample divider with a registered one-cycle strobe.
// `tick` flags the cycle whose clock edge will raise `stb`.
module qam_strobe_gen #(
  parameter int SAMPLE_DIV = 6
) (
  input  logic axi_clk,
  input  logic axi_rst,
  input  logic clear,
  input  logic enable,
  output logic tick,
  output logic stb
);

  localparam int CW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && !clear && (cnt == LAST);

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      cnt <= '0;
      stb <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
      stb <= 1'b0;
    end else if (enable) begin
      stb <= (cnt == LAST);
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end else begin
      stb <= 1'b0;
    end
  end

endmodule

// File: rtl/qam_mod_scheduler.sv
// Burst sequencer: waits for carrier phase zero, paces filter samples and holds
// the multiplier FIFO read enable for the burst plus a fixed drain tail.
module qam_mod_scheduler
  import parameter_def::*;
#(
  parameter int SAMPLE_DIV   = SAMPLE_DIV_DEF,
  parameter int LEN_WIDTH    = 16,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic                 axi_clk,
  input  logic                 axi_rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [LEN_WIDTH-1:0] start_len,
  input  logic                 abort,
  input  logic                 carrier_zero,
  input  logic                 fifo_empty,
  output logic                 sample_stb,
  output logic                 mod_en,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 err_underflow
);

  localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES);

  qam_sched_state_t     state;
  logic [LEN_WIDTH-1:0] remaining;
  logic [7:0]           drain_cnt;
  logic                 tick;

  // The divider only runs in RUN; abort clears it so no strobe escapes the edge it lands on.
  qam_strobe_gen #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_strobe (
    .axi_clk (axi_clk),
    .axi_rst (axi_rst),
    .clear   ((state != RUN) || abort),
    .enable  (state == RUN),
    .tick    (tick),
    .stb     (sample_stb)
  );

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      state         <= IDLE;
      remaining     <= '0;
      drain_cnt     <= '0;
      start_ready   <= 1'b1;
      mod_en        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (mod_en && fifo_empty) err_underflow <= 1'b1;

      if (abort && (state != IDLE)) begin
        state       <= IDLE;
        remaining   <= '0;
        drain_cnt   <= '0;
        start_ready <= 1'b1;
        mod_en      <= 1'b0;
        busy        <= 1'b0;
        aborted     <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start_valid) begin
              remaining     <= start_len;
              err_underflow <= 1'b0;
              if (start_len == '0) begin
                done <= 1'b1;
              end else begin
                state       <= ARM;
                start_ready <= 1'b0;
                busy        <= 1'b1;
              end
            end
          end
          ARM: begin
            if (carrier_zero) begin
              state  <= RUN;
              mod_en <= 1'b1;
            end
          end
          RUN: begin
            // The final strobe hands over to DRAIN without counting remaining to zero.
            if (tick) begin
              if (remaining == LEN_WIDTH'(1)) begin
                state     <= DRAIN;
                drain_cnt <= DRAIN_LOAD;
              end else begin
                remaining <= remaining - LEN_WIDTH'(1);
              end
            end
          end
          DRAIN: begin
            if (drain_cnt == 8'd1) begin
              state       <= IDLE;
              remaining   <= '0;
              drain_cnt   <= '0;
              start_ready <= 1'b1;
              mod_en      <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt - 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qam_mod_scheduler.sv
// Bench for qam_mod_scheduler: per-cycle output vector compared against burst
// timing windows computed arithmetically from length, carrier-zero and abort cycles.
module tb_qam_mod_scheduler;

  localparam int SD = 6;
  localparam int LW = 16;
  localparam int DC = 4;

  logic          axi_clk = 1'b0;
  logic          axi_rst;
  logic          start_valid;
  logic          start_ready;
  logic [LW-1:0] start_len;
  logic          abort;
  logic          carrier_zero;
  logic          fifo_empty;
  logic          sample_stb;
  logic          mod_en;
  logic          busy;
  logic          done;
  logic          aborted;
  logic          err_underflow;

  int   tests_run = 0;
  int   tests_failed = 0;
  logic err_m;

  qam_mod_scheduler #(
    .SAMPLE_DIV  (SD),
    .LEN_WIDTH   (LW),
    .DRAIN_CYCLES(DC)
  ) dut (
    .axi_clk      (axi_clk),
    .axi_rst      (axi_rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .start_len    (start_len),
    .abort        (abort),
    .carrier_zero (carrier_zero),
    .fifo_empty   (fifo_empty),
    .sample_stb   (sample_stb),
    .mod_en       (mod_en),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .err_underflow(err_underflow)
  );

  always #5 axi_clk = ~axi_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b", tag, got[6:0], exp[6:0]);
    end
  endtask

  // {start_ready, sample_stb, mod_en, busy, done, aborted, err_underflow}
  function automatic logic [6:0] obs();
    return {start_ready, sample_stb, mod_en, busy, done, aborted, err_underflow};
  endfunction

  // r = cycles since the accept cycle. cz_r: first carrier_zero after accept.
  // ab_r: cycle abort is driven (-1 = none). empty_mode: 0 never, 1 random, 2 always.
  task automatic run_burst(input int n, input int cz_r, input bit cz_at_accept, input int ab_r,
                           input bit abort_idle, input int empty_mode, input string name);
    int   end_r, last, k;
    logic cut, sr, stb, me, bs, dn, abt;
    end_r = cz_r + 1 + n * SD + DC;
    if (n == 0) last = 1;
    else if (ab_r >= 1 && ab_r < end_r) last = ab_r + 1;
    else last = end_r;
    for (int r = 0; r <= last; r++) begin
      @(posedge axi_clk); #1;
      start_valid  = (r == 0);
      start_len    = LW'(n);
      abort        = (r == 0) ? abort_idle : (r == ab_r);
      if (r == 0) carrier_zero = cz_at_accept;
      else if (r < cz_r) carrier_zero = 1'b0;
      else if (r == cz_r) carrier_zero = 1'b1;
      else carrier_zero = 1'($urandom_range(0, 1));
      fifo_empty = (empty_mode == 2) ? 1'b1 : (empty_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge axi_clk);
      if (n == 0) begin
        {stb, me, bs, abt} = 4'b0000;
        dn = (r == 1);
      end else begin
        cut = (ab_r >= 1) && (r > ab_r);
        bs  = (r >= 1) && (r <= end_r - 1) && !cut;
        me  = (r >= cz_r + 1) && (r <= end_r - 1) && !cut;
        k   = r - cz_r - 1;
        stb = !cut && (k > 0) && (k % SD == 0) && (k / SD <= n);
        dn  = (r == end_r) && !cut;
        abt = (ab_r >= 1) && (r == ab_r + 1);
      end
      sr = !bs;
      check_eq($sformatf("%s r%0d", name, r), 32'(obs()), 32'({sr, stb, me, bs, dn, abt, err_m}));
      if (r == 0) err_m = 1'b0;
      if (me && fifo_empty) err_m = 1'b1;
    end
  endtask

  task automatic idle_cycles(input int cnt, input string name);
    for (int i = 0; i < cnt; i++) begin
      @(posedge axi_clk); #1;
      start_valid  = 1'b0;
      abort        = 1'($urandom_range(0, 1));
      carrier_zero = 1'($urandom_range(0, 1));
      fifo_empty   = 1'($urandom_range(0, 1));
      @(negedge axi_clk);
      check_eq($sformatf("%s i%0d", name, i), 32'(obs()), 32'({6'b100000, err_m}));
    end
  endtask

  task automatic reset_mid_run();
    @(posedge axi_clk); #1;
    start_valid = 1'b1; start_len = LW'(4); abort = 1'b0; carrier_zero = 1'b0; fifo_empty = 1'b0;
    @(posedge axi_clk); #1;
    start_valid = 1'b0; carrier_zero = 1'b1;
    @(posedge axi_clk); #1;
    carrier_zero = 1'b0;
    repeat (3) @(posedge axi_clk);
    #2;
    check_eq("rst_pre_run", 32'(obs()), 32'(7'b0011000));
    axi_rst = 1'b1;
    #1;
    check_eq("rst_async", 32'(obs()), 32'(7'b1000000));
    @(negedge axi_clk);
    axi_rst = 1'b0;
    err_m = 1'b0;
  endtask

  initial begin
    int n, cz_r, ab_r, end_r;
    axi_rst = 1'b1;
    start_valid = 1'b0; start_len = '0; abort = 1'b0; carrier_zero = 1'b0; fifo_empty = 1'b0;
    err_m = 1'b0;
    repeat (3) @(posedge axi_clk);
    @(negedge axi_clk);
    check_eq("reset_values", 32'(obs()), 32'(7'b1000000));
    axi_rst = 1'b0;

    run_burst(3, 5, 1'b0, -1, 1'b0, 0, "len3");
    run_burst(0, 1, 1'b0, -1, 1'b0, 0, "len0");
    idle_cycles(2, "gap0");
    run_burst(2, 10, 1'b1, -1, 1'b0, 0, "cz_accept");
    run_burst(2, 2, 1'b0, 2 + 1 + 2 * SD, 1'b0, 0, "abort_stb2");
    run_burst(3, 3, 1'b0, -1, 1'b0, 2, "underflow");
    idle_cycles(4, "uf_idle");
    run_burst(1, 2, 1'b0, -1, 1'b0, 0, "uf_clear");
    run_burst(2, 1, 1'b0, 1 + 1 + 2 * SD + DC - 1, 1'b1, 0, "abort_drain_end");
    run_burst(4, 3, 1'b0, 2, 1'b0, 0, "abort_arm");
    reset_mid_run();
    run_burst(1, 3, 1'b0, -1, 1'b0, 0, "after_rst");

    for (int b = 0; b < 24; b++) begin
      n     = $urandom_range(0, 5);
      cz_r  = $urandom_range(1, 8);
      end_r = cz_r + 1 + n * SD + DC;
      ab_r  = ($urandom_range(0, 3) == 0 && n > 0) ? $urandom_range(1, end_r - 1) : -1;
      run_burst(n, cz_r, 1'($urandom_range(0, 1)), ab_r, 1'($urandom_range(0, 1)),
                $urandom_range(0, 1), $sformatf("rnd%0d", b));
      idle_cycles($urandom_range(0, 3), $sformatf("rgap%0d", b));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/qam_mod_scheduler.md
# qam_mod_scheduler

Burst sequencer for the QAM-16 modulator datapath. It accepts a burst request of N symbols and waits for the carrier zero flag so modulation starts phase-aligned. It then paces filter samples at the filter sample rate and holds the multiplier-stage FIFO read enable for the burst plus a fixed drain tail. It sits between the frame source and the shaping-filter / I·cos − Q·sin multiplier stage.

## Interface
- SAMPLE_DIV, 6: system clocks per filter sample; legal 2..64.
- LEN_WIDTH, 16: width of burst length in samples.
- DRAIN_CYCLES, 4: cycles `mod_en` stays high after the last sample strobe (FIFO read + DSP + sum latency); legal 1..255.

Ports:
- axi_clk  in  1  system clock.
- axi_rst  in  1  asynchronous, active-high reset.
- start_valid  in  1  burst request.
- start_ready  out  1  high only in IDLE; request accepted when `start_valid && start_ready`.
- start_len  in  LEN_WIDTH  burst length in samples; sampled on accept.
- abort  in  1  cancel current burst.
- carrier_zero  in  1  carrier phase-zero flag from the carrier generator.
- fifo_empty  in  1  empty flag of the multiplier sync FIFO.
- sample_stb  out  1  one-cycle filter sample strobe.
- mod_en  out  1  sync-FIFO read enable / modulation enable.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse at normal burst completion.
- aborted  out  1  one-cycle pulse when abort takes effect.
- err_underflow  out  1  sticky error flag.

## Operation
- States: IDLE, ARM, RUN, DRAIN.
- **IDLE**
  - On accept, latch `remaining = start_len`, clear `err_underflow`.
  - Go to ARM if `start_len ≠ 0`.
  - If `start_len = 0`, stay in IDLE and pulse `done` next cycle.
- **ARM**
  - Wait for `carrier_zero`. A zero in the accept cycle itself is ignored.
  - On `carrier_zero`, go to RUN and clear the divider to 0.
- **RUN**
  - Divider counts 0..SAMPLE_DIV−1 and wraps.
  - `sample_stb` is high when divider = SAMPLE_DIV−1.
  - Each strobe decrements `remaining`.
  - The strobe with `remaining = 1` moves to DRAIN; drain counter loads DRAIN_CYCLES.
- **DRAIN**
  - Drain counter decrements each cycle.
  - At 1, go to IDLE and pulse `done` in the same cycle as the transition.
- `mod_en` = (state == RUN) || (state == DRAIN).
- `abort` (any non-IDLE state, sampled on clock edge):
  - Next state IDLE; `aborted` pulses the following cycle.
  - No `done`; `mod_en` and `sample_stb` drop immediately.
  - Abort in IDLE is ignored.
  - Abort has priority over every same-cycle transition, including the final strobe or the drain end.
- `err_underflow`: set when `mod_en && fifo_empty`; held until the next accept.
- Counters are unsigned, with no wrap beyond their documented ranges. `remaining` never underflows.

## Timing
- Reset values: state IDLE; `start_ready`=1; all other outputs 0; all counters 0.
- Reset asserted mid-burst: outputs go to reset values asynchronously.
- ARM→RUN: `mod_en` rises the cycle after the `carrier_zero` sample.
- First `sample_stb` comes SAMPLE_DIV cycles after `mod_en` rises.
- Burst of N samples: `mod_en` is high for exactly N·SAMPLE_DIV + DRAIN_CYCLES cycles.
- `done` is high in the last `mod_en` cycle + 1 (the cycle state returns to IDLE).
- Back-to-back: `start_ready` is high in the cycle after `done`; a new accept is possible there.
- All outputs are registered.

## Structure
- Package `parameter_def` gets:
  - `typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} qam_sched_state_t`;
  - default constants SAMPLE_DIV_DEF = 6 and DRAIN_CYCLES_DEF = 4.
- One sub-module, `qam_strobe_gen`:
  - clear / enable inputs, modulo-SAMPLE_DIV counter, registered strobe output;
  - reusable by the demodulator side.

## Test plan
- Reset then `start_len`=3, `carrier_zero` 5 cycles later:
  - `mod_en` high 3·6+4 = 22 cycles;
  - `sample_stb` at offsets 6, 12, 18 after `mod_en` rise;
  - one `done`; `err_underflow`=0.
- `start_len`=0: accepted, never leaves IDLE, `done` pulses once, `mod_en` stays 0.
- `carrier_zero` high in the accept cycle and again 10 cycles later: RUN starts only after the second zero.
- `abort` in the same cycle as the 2nd of 2 strobes:
  - state IDLE next cycle, `aborted` pulses, no `done`;
  - `remaining` is not observed to reach 0.
- `fifo_empty`=1 during RUN of burst 1: `err_underflow` sticks through IDLE, clears on the next accept.
- `axi_rst` asserted mid-RUN between clock edges: outputs reach reset values before the next edge. After release, a `start_len`=1 burst runs normally (`mod_en` 10 cycles).
